// File: rtl/led_pattern_gen.sv
`timescale 1ns/1ps
// Five-LED pattern generator: off, on, blink, PWM breathe and one-hot chase.
// Pattern timing comes from an internal prescaled tick; LED drives are registered.
module led_pattern_gen #(
  parameter int PRESCALE    = 12000,
  parameter int PWM_BITS    = 8,
  parameter int STEP_TICKS  = 4,
  parameter int BLINK_TICKS = 500
) (
  input  logic       CLK,
  input  logic       RSTN,
  input  logic [2:0] MODE_IN,
  input  logic       MODE_LD,
  output logic [2:0] MODE,
  output logic       TICK,
  output logic       LED0,
  output logic       LED1,
  output logic       LED2,
  output logic       LED3,
  output logic       LED4
);

  typedef enum logic [2:0] {
    M_OFF     = 3'd0,
    M_ON      = 3'd1,
    M_BLINK   = 3'd2,
    M_BREATHE = 3'd3,
    M_CHASE   = 3'd4
  } mode_t;

  localparam int PRE_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int STEP_MAX = (STEP_TICKS > BLINK_TICKS) ? STEP_TICKS : BLINK_TICKS;
  localparam int STEP_W   = (STEP_MAX > 1) ? $clog2(STEP_MAX) : 1;

  localparam logic [PRE_W-1:0]    PRE_LAST   = PRE_W'(PRESCALE - 1);
  localparam logic [PRE_W-1:0]    PRE_ONE    = PRE_W'(1'b1);
  localparam logic [STEP_W-1:0]   STEP_LAST  = STEP_W'(STEP_TICKS - 1);
  localparam logic [STEP_W-1:0]   BLINK_LAST = STEP_W'(BLINK_TICKS - 1);
  localparam logic [STEP_W-1:0]   STEP_ONE   = STEP_W'(1'b1);
  localparam logic [PWM_BITS-1:0] B_ONE      = PWM_BITS'(1'b1);
  localparam logic [PWM_BITS-1:0] B_MAX      = {PWM_BITS{1'b1}};
  localparam logic [PWM_BITS-1:0] B_NEAR_MAX = B_MAX - B_ONE;

  mode_t               mode_r;
  logic [PRE_W-1:0]    pre_r;
  logic [PRE_W-1:0]    pre_nxt_s;
  logic                tick_r;
  logic [PWM_BITS-1:0] pwm_r;
  logic [PWM_BITS-1:0] bright_r;
  logic [PWM_BITS-1:0] bright_nxt_s;
  logic                dir_down_r;
  logic                dir_down_nxt_s;
  logic [STEP_W-1:0]   step_r;
  logic [STEP_W-1:0]   step_nxt_s;
  logic                phase_r;
  logic                phase_nxt_s;
  logic [2:0]          pos_r;
  logic [2:0]          pos_nxt_s;
  logic [4:0]          led_r;
  logic [4:0]          led_nxt_s;
  logic                load_s;

  // Out-of-range mode requests are dropped without touching any state.
  assign load_s = MODE_LD & (MODE_IN <= 3'd4);

  // Prescaler next count; a load restarts the tick period.
  always_comb begin
    pre_nxt_s = pre_r;
    if (load_s) begin
      pre_nxt_s = {PRE_W{1'b0}};
    end else if (pre_r == PRE_LAST) begin
      pre_nxt_s = {PRE_W{1'b0}};
    end else begin
      pre_nxt_s = pre_r + PRE_ONE;
    end
  end

  // Pattern state next values; a load takes priority over a coincident tick.
  always_comb begin
    step_nxt_s     = step_r;
    phase_nxt_s    = phase_r;
    pos_nxt_s      = pos_r;
    bright_nxt_s   = bright_r;
    dir_down_nxt_s = dir_down_r;
    if (load_s) begin
      step_nxt_s     = {STEP_W{1'b0}};
      phase_nxt_s    = 1'b0;
      pos_nxt_s      = 3'd0;
      bright_nxt_s   = {PWM_BITS{1'b0}};
      dir_down_nxt_s = 1'b0;
    end else if (tick_r) begin
      case (mode_r)
        M_BLINK: begin
          if (step_r == BLINK_LAST) begin
            step_nxt_s  = {STEP_W{1'b0}};
            phase_nxt_s = ~phase_r;
          end else begin
            step_nxt_s = step_r + STEP_ONE;
          end
        end
        M_BREATHE: begin
          if (step_r == STEP_LAST) begin
            step_nxt_s = {STEP_W{1'b0}};
            // Direction flips on arrival at an endpoint so it is never repeated.
            if (!dir_down_r) begin
              bright_nxt_s = bright_r + B_ONE;
              if (bright_r == B_NEAR_MAX) begin
                dir_down_nxt_s = 1'b1;
              end else begin
                dir_down_nxt_s = dir_down_r;
              end
            end else begin
              bright_nxt_s = bright_r - B_ONE;
              if (bright_r == B_ONE) begin
                dir_down_nxt_s = 1'b0;
              end else begin
                dir_down_nxt_s = dir_down_r;
              end
            end
          end else begin
            step_nxt_s = step_r + STEP_ONE;
          end
        end
        M_CHASE: begin
          if (step_r == BLINK_LAST) begin
            step_nxt_s = {STEP_W{1'b0}};
            if (pos_r == 3'd4) begin
              pos_nxt_s = 3'd0;
            end else begin
              pos_nxt_s = pos_r + 3'd1;
            end
          end else begin
            step_nxt_s = step_r + STEP_ONE;
          end
        end
        default: begin
          step_nxt_s = step_r;
        end
      endcase
    end else begin
      step_nxt_s = step_r;
    end
  end

  // LED levels decoded from the current pattern state.
  always_comb begin
    led_nxt_s = 5'b00000;
    case (mode_r)
      M_OFF:     led_nxt_s = 5'b00000;
      M_ON:      led_nxt_s = 5'b11111;
      M_BLINK:   led_nxt_s = {5{phase_r}};
      M_BREATHE: led_nxt_s = {5{pwm_r < bright_r}};
      M_CHASE:   led_nxt_s = 5'b00001 << pos_r;
      default:   led_nxt_s = 5'b00000;
    endcase
  end

  // All state and output registers.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      mode_r     <= M_OFF;
      pre_r      <= {PRE_W{1'b0}};
      tick_r     <= 1'b0;
      pwm_r      <= {PWM_BITS{1'b0}};
      bright_r   <= {PWM_BITS{1'b0}};
      dir_down_r <= 1'b0;
      step_r     <= {STEP_W{1'b0}};
      phase_r    <= 1'b0;
      pos_r      <= 3'd0;
      led_r      <= 5'b00000;
    end else begin
      if (load_s) begin
        mode_r <= mode_t'(MODE_IN);
      end else begin
        mode_r <= mode_r;
      end
      pre_r      <= pre_nxt_s;
      tick_r     <= (pre_nxt_s == PRE_LAST);
      pwm_r      <= pwm_r + B_ONE;
      bright_r   <= bright_nxt_s;
      dir_down_r <= dir_down_nxt_s;
      step_r     <= step_nxt_s;
      phase_r    <= phase_nxt_s;
      pos_r      <= pos_nxt_s;
      led_r      <= led_nxt_s;
    end
  end

  assign MODE = mode_r;
  assign TICK = tick_r;
  assign LED0 = led_r[0];
  assign LED1 = led_r[1];
  assign LED2 = led_r[2];
  assign LED3 = led_r[3];
  assign LED4 = led_r[4];

endmodule

// File: tb/tb_led_pattern_gen.sv
`timescale 1ns/1ps
// Directed bench for led_pattern_gen using small parameters
// (PRESCALE=4, PWM_BITS=3, STEP_TICKS=1, BLINK_TICKS=2).
module tb_led_pattern_gen;

  logic       CLK = 1'b0;
  logic       RSTN = 1'b0;
  logic [2:0] MODE_IN = 3'd0;
  logic       MODE_LD = 1'b0;
  logic [2:0] MODE;
  logic       TICK;
  logic       LED0, LED1, LED2, LED3, LED4;
  logic [4:0] leds;

  int tests = 0;
  int fails = 0;
  int cyc;

  led_pattern_gen #(
    .PRESCALE(4), .PWM_BITS(3), .STEP_TICKS(1), .BLINK_TICKS(2)
  ) dut (
    .CLK(CLK), .RSTN(RSTN), .MODE_IN(MODE_IN), .MODE_LD(MODE_LD),
    .MODE(MODE), .TICK(TICK),
    .LED0(LED0), .LED1(LED1), .LED2(LED2), .LED3(LED3), .LED4(LED4)
  );

  assign leds = {LED4, LED3, LED2, LED1, LED0};

  always #5 CLK = ~CLK;

  // Clock edges since the last reset release; the PWM counter equals this mod 8.
  always @(posedge CLK or negedge RSTN) begin
    if (!RSTN) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  task automatic load_mode(input logic [2:0] m);
    MODE_IN = m;
    MODE_LD = 1'b1;
    @(negedge CLK);
    MODE_LD = 1'b0;
  endtask

  task automatic test_reset();
    logic exp_tick;
    RSTN = 1'b0;
    repeat (3) @(negedge CLK);
    tests++;
    if (leds !== 5'b00000) begin fails++; $display("FAIL reset_leds: got %b expected 00000", leds); end
    tests++;
    if (MODE !== 3'd0) begin fails++; $display("FAIL reset_mode: got %0d expected 0", MODE); end
    tests++;
    if (TICK !== 1'b0) begin fails++; $display("FAIL reset_tick: got %b expected 0", TICK); end
    RSTN = 1'b1;
    for (int n = 1; n <= 12; n++) begin
      @(negedge CLK);
      exp_tick = ((n % 4) == 3);
      tests++;
      if (TICK !== exp_tick) begin
        fails++; $display("FAIL tick_period n=%0d: got %b expected %b", n, TICK, exp_tick);
      end
    end
  endtask

  task automatic test_on();
    load_mode(3'd1);
    tests++;
    if (MODE !== 3'd1) begin fails++; $display("FAIL on_mode: got %0d expected 1", MODE); end
    tests++;
    if (leds !== 5'b00000) begin fails++; $display("FAIL on_lag: got %b expected 00000", leds); end
    @(negedge CLK);
    tests++;
    if (leds !== 5'b11111) begin fails++; $display("FAIL on_leds: got %b expected 11111", leds); end
    load_mode(3'd6);
    for (int n = 0; n < 4; n++) begin
      tests++;
      if (MODE !== 3'd1 || leds !== 5'b11111) begin
        fails++; $display("FAIL ignore_bad_mode n=%0d: got mode %0d leds %b expected mode 1 leds 11111", n, MODE, leds);
      end
      @(negedge CLK);
    end
  endtask

  task automatic test_blink();
    logic [4:0] exp_leds;
    load_mode(3'd2);
    tests++;
    if (MODE !== 3'd2) begin fails++; $display("FAIL blink_mode: got %0d expected 2", MODE); end
    for (int n = 1; n <= 24; n++) begin
      @(negedge CLK);
      exp_leds = ((((n - 1) / 8) % 2) == 1) ? 5'b11111 : 5'b00000;
      tests++;
      if (leds !== exp_leds) begin
        fails++; $display("FAIL blink n=%0d: got %b expected %b", n, leds, exp_leds);
      end
    end
  endtask

  task automatic test_breathe();
    int         seq [15] = '{1, 2, 3, 4, 5, 6, 7, 6, 5, 4, 3, 2, 1, 0, 1};
    int         b_prev;
    int         pwm_prev;
    logic [4:0] exp_leds;
    load_mode(3'd3);
    tests++;
    if (MODE !== 3'd3) begin fails++; $display("FAIL breathe_mode: got %0d expected 3", MODE); end
    b_prev   = 0;
    pwm_prev = cyc % 8;
    for (int n = 1; n <= 60; n++) begin
      @(negedge CLK);
      exp_leds = (pwm_prev < b_prev) ? 5'b11111 : 5'b00000;
      tests++;
      if (leds !== exp_leds) begin
        fails++; $display("FAIL breathe n=%0d B=%0d pwm=%0d: got %b expected %b", n, b_prev, pwm_prev, leds, exp_leds);
      end
      if ((n % 4) == 0) b_prev = seq[n / 4 - 1];
      pwm_prev = cyc % 8;
    end
  endtask

  task automatic test_chase();
    logic [4:0] exp_leds;
    load_mode(3'd4);
    tests++;
    if (MODE !== 3'd4) begin fails++; $display("FAIL chase_mode: got %0d expected 4", MODE); end
    for (int i = 0; i < 6; i++) begin
      for (int c = 0; c < 8; c++) begin
        @(negedge CLK);
        exp_leds = 5'b00001 << (i % 5);
        tests++;
        if (leds !== exp_leds) begin
          fails++; $display("FAIL chase step=%0d c=%0d: got %b expected %b", i, c, leds, exp_leds);
        end
      end
    end
    #2;
    RSTN = 1'b0;
    #1;
    tests++;
    if (leds !== 5'b00000 || MODE !== 3'd0) begin
      fails++; $display("FAIL async_reset: got leds %b mode %0d expected leds 00000 mode 0", leds, MODE);
    end
    @(negedge CLK);
    RSTN = 1'b1;
  endtask

  task automatic test_collision();
    logic       exp_tick;
    logic [4:0] exp_leds;
    load_mode(3'd2);
    for (int n = 1; n <= 7; n++) begin
      @(negedge CLK);
      exp_tick = (n == 3) || (n == 7);
      tests++;
      if (TICK !== exp_tick) begin
        fails++; $display("FAIL coll_pre_tick n=%0d: got %b expected %b", n, TICK, exp_tick);
      end
    end
    load_mode(3'd4);
    tests++;
    if (MODE !== 3'd4 || leds !== 5'b00000) begin
      fails++; $display("FAIL coll_load: got mode %0d leds %b expected mode 4 leds 00000", MODE, leds);
    end
    for (int n = 1; n <= 9; n++) begin
      @(negedge CLK);
      exp_leds = (n == 9) ? 5'b00010 : 5'b00001;
      exp_tick = (n == 3) || (n == 7);
      tests++;
      if (leds !== exp_leds) begin
        fails++; $display("FAIL coll_chase n=%0d: got %b expected %b", n, leds, exp_leds);
      end
      tests++;
      if (TICK !== exp_tick) begin
        fails++; $display("FAIL coll_tick n=%0d: got %b expected %b", n, TICK, exp_tick);
      end
    end
  endtask

  initial begin
    @(negedge CLK);
    test_reset();
    test_on();
    test_blink();
    test_breathe();
    test_chase();
    test_collision();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/led_pattern_gen.md
Name: led_pattern_gen

Overview:
- Pattern generator sitting directly upstream of the board LED output stage; produces the five LED drive levels LED0..LED4.
- Runs from the board clock. Selects one of five display modes: off, on, blink, PWM breathe, one-hot chase.
- Derives all pattern timing from an internal prescaled tick.
- Outputs are registered and drive the LED pins directly.

Parameters:
- PRESCALE, 12000, CLK cycles per tick (1 kHz at 12 MHz); must be >= 2.
- PWM_BITS, 8, width of the PWM counter and brightness register.
- STEP_TICKS, 4, ticks per breathe brightness step; must be >= 1.
- BLINK_TICKS, 500, ticks per blink toggle and per chase advance; must be >= 1.

Ports:
- CLK, input, 1, board clock.
- RSTN, input, 1, asynchronous active-low reset.
- MODE_IN, input, 3, requested mode: 0 OFF, 1 ON, 2 BLINK, 3 BREATHE, 4 CHASE.
- MODE_LD, input, 1, one-cycle strobe that latches MODE_IN.
- MODE, output, 3, currently active mode.
- TICK, output, 1, one-cycle prescaler pulse, exported for debug.
- LED0, output, 1, LED drive (registered).
- LED1, output, 1, LED drive (registered).
- LED2, output, 1, LED drive (registered).
- LED3, output, 1, LED drive (registered).
- LED4, output, 1, LED drive (registered).

Behaviour:
- **Reset (RSTN=0, asynchronous):**
  - MODE=0, TICK=0, LED0..LED4=0.
  - Prescaler, PWM counter, brightness, direction (up), step counter, blink phase and chase position all cleared to 0.
  - Release is synchronous to CLK. Reset asserted mid-pattern aborts it immediately.
- **Prescaler:**
  - Counts 0..PRESCALE-1 and wraps to 0.
  - TICK=1 for exactly the cycle in which the count equals PRESCALE-1 (registered).
- **PWM counter:**
  - PWM_BITS wide, free-running, increments every CLK, wraps naturally.
- **Mode load:**
  - MODE_LD=1 with MODE_IN<=4: MODE takes MODE_IN on the next edge.
  - On the same edge, the prescaler, step counter, blink phase, chase position and brightness clear to 0 and direction is set to up.
  - MODE_IN 5..7: the strobe is ignored entirely; no state changes.
  - Reloading the current mode restarts that pattern.
- **Tick/load collision:** MODE_LD coinciding with TICK means the load wins and the tick's pattern event is discarded.
- **OFF:** all LEDs 0.
- **ON:** all LEDs 1.
- **BLINK:**
  - Step counter counts ticks 0..BLINK_TICKS-1.
  - On the tick that reaches BLINK_TICKS-1, the phase toggles and the counter wraps.
  - All LEDs equal phase; the first period after load is dark.
- **BREATHE:**
  - Brightness B is updated on every STEP_TICKS-th tick.
  - Direction up: B+1. When B reaches 2^PWM_BITS-1, direction flips to down.
  - Direction down: B-1. When B reaches 0, direction flips to up.
  - Endpoints are not repeated: sequence is ...254,255,254...1,0,1...
  - All LEDs = (pwm_cnt < B). B=0 gives never on; B=max gives on for (2^PWM_BITS-1) of every 2^PWM_BITS cycles.
- **CHASE:**
  - Position P advances every BLINK_TICKS ticks: 0→1→2→3→4→0.
  - LEDk = (P==k). LED0 is lit immediately after load.
- **Latency:** LED outputs are registered, so each lags the internal pattern state by 1 CLK.
- **Counter widths:** widths are sized as clog2 of the respective parameter. No counter overflows for legal parameters.

Test Plan:
All scenarios use PRESCALE=4, PWM_BITS=3, STEP_TICKS=1, BLINK_TICKS=2.

1. Reset with RSTN=0 for 3 cycles, then release.
   - Required: LEDs=00000 and MODE=0 during reset.
   - Required: first TICK on cycle 4 after release, then every 4 cycles.
2. MODE_IN=1, MODE_LD pulse.
   - Required: MODE=1 on the next edge; LED0..4=1 one cycle later.
   - Then MODE_IN=6 with MODE_LD pulse: MODE stays 1 and LEDs are unchanged.
3. Load mode 2 (BLINK).
   - Required: LEDs=0 for the first 2 ticks (8 CLK), then 1 for 8 CLK, then 0, repeating.
4. Load mode 3 (BREATHE), sample B at each tick.
   - Required: 1,2,3,4,5,6,7,6,5,4,3,2,1,0,1.
   - Required: at B=5, each LED is high for exactly 5 of every 8 CLK.
5. Load mode 4 (CHASE).
   - Required: lit LED index 0,1,2,3,4,0 with 8 CLK per step.
   - Then pulse RSTN low mid-step: all LEDs 0 immediately (asynchronous) and MODE=0.
6. Assert MODE_LD with MODE_IN=4 on the same cycle as TICK while in BLINK.
   - Required: no blink toggle occurs; chase starts at P=0; the next TICK comes 4 CLK after the load edge.
